// File: rtl/reg_s_pl_feeder.sv
// Elastic FIFO stage feeding a synchronous parallel-load register's d/enable pair.
// One word is presented per cycle and loaded whenever the downstream side allows it.
module reg_s_pl_feeder #(
    parameter int width = 8,
    parameter int depth = 4,
    localparam int CW = $clog2(depth + 1),
    localparam int PW = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [width-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_allow,
    output logic [width-1:0]  reg_d,
    output logic              reg_enable,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic [15:0]       load_total
);

    // Handshake: a word moves upstream->FIFO only on a cycle with in_valid & in_ready;
    // in_ready depends on registered state only, and the producer holds in_data until then.
    logic [width-1:0] mem [depth];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    // Explicit wrap at depth-1 so non-power-of-two depths index correctly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full       = (count == CW'(depth));
    assign empty      = (count == '0);
    assign in_ready   = !full && !reset;
    assign push       = in_valid && in_ready;
    assign pop        = load_allow && !empty && !reset;
    assign reg_enable = pop;
    assign reg_d      = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            load_total <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr     <= next_ptr(rd_ptr);
                load_total <= load_total + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_s_pl_feeder.sv
// Bench for reg_s_pl_feeder: queue-based model checked every cycle plus directed
// scenarios with literal expectations on load order, latency and counters.
module tb_reg_s_pl_feeder;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          load_allow = 1'b0;
    logic          in_ready;
    logic [W-1:0]  reg_d;
    logic          reg_enable;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic [15:0]   load_total;

    reg_s_pl_feeder #(.width(W), .depth(D)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .load_allow(load_allow), .reg_d(reg_d),
        .reg_enable(reg_enable), .count(count), .full(full), .empty(empty),
        .load_total(load_total)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- downstream register and load log ----------------
    logic [W-1:0] q_reg = '0;
    logic [W-1:0] log_q[$];
    always @(posedge clk) begin
        if (reg_enable) begin
            q_reg <= reg_d;
            log_q.push_back(reg_d);
        end
    end

    // ---------------- behavioural model ----------------
    logic [W-1:0] exp_q[$];
    logic [15:0]  model_total = '0;
    bit           cmp_en = 1'b0;

    always @(posedge clk) begin
        bit do_pop, do_push;
        if (reset) begin
            exp_q.delete();
            model_total = '0;
        end else begin
            do_pop  = load_allow && (exp_q.size() > 0);
            do_push = in_valid && (exp_q.size() < D);
            if (do_pop) begin
                void'(exp_q.pop_front());
                model_total = model_total + 16'd1;
            end
            if (do_push) exp_q.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            int n;
            n = exp_q.size();
            check("in_ready",   in_ready,   !reset && n < D);
            check("reg_enable", reg_enable, !reset && load_allow && n > 0);
            check("reg_d",      reg_d,      (n > 0) ? exp_q[0] : '0);
            check("count",      count,      n);
            check("full",       full,       n == D);
            check("empty",      empty,      n == 0);
            check("load_total", load_total, model_total);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input logic [W-1:0] first, input int n);
        check({name, "_len"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++)
            check({name, "_word"}, log_q[i], first + W'(i));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int k;
        int push_k;
        int pops;

        // T1: reset held with in_valid and load_allow high
        reset = 1'b1; in_valid = 1'b1; load_allow = 1'b1; in_data = 8'hFF;
        tick();
        cmp_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            check("t1_in_ready", in_ready, 0);
            check("t1_reg_enable", reg_enable, 0);
            check("t1_count", count, 0);
            check("t1_empty", empty, 1);
            check("t1_load_total", load_total, 0);
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; load_allow = 1'b0;
        tick();

        // T2: single-word latency
        in_data = 8'hA5; in_valid = 1'b1; load_allow = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        check("t2_reg_d", reg_d, 8'hA5);
        check("t2_reg_enable", reg_enable, 1);
        tick();
        #2;
        check("t2_q", q_reg, 8'hA5);
        check("t2_count", count, 0);
        check("t2_load_total", load_total, 1);
        load_allow = 1'b0;
        tick();

        // T3: fill to full, fifth word held, then drain in order
        for (int i = 1; i <= 4; i++) begin
            in_data = W'(i); in_valid = 1'b1;
            tick();
        end
        in_data = 8'h05;
        #2;
        check("t3_full", full, 1);
        check("t3_in_ready", in_ready, 0);
        check("t3_count", count, 4);
        tick();
        tick();
        check("t3_count_held", count, 4);
        log_q.delete();
        load_allow = 1'b1;
        push_k = -1;
        for (k = 0; k < 8; k++) begin
            #2;
            if (in_valid && in_ready && push_k < 0) push_k = k;
            tick();
            if (push_k >= 0) in_valid = 1'b0;
        end
        check("t3_fifth_push_cycle", push_k, 1);
        check_log("t3_order", 8'h01, 5);
        load_allow = 1'b0;

        // T4: simultaneous push/pop at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            in_data = 8'h10 + W'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2;
        check("t4_count_start", count, 2);
        log_q.delete();
        load_allow = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h12 + W'(i);
            tick();
            #2;
            check("t4_count_steady", count, 2);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_log("t4_order", 8'h10, 12);
        check("t4_empty", empty, 1);
        load_allow = 1'b0;

        // T5: reset with three words buffered
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h31 + W'(i); in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2;
        check("t5_count_pre", count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        check("t5_count", count, 0);
        check("t5_empty", empty, 1);
        check("t5_load_total", load_total, 0);
        log_q.delete();
        in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; load_allow = 1'b1;
        tick();
        check_log("t5_next", 8'h5A, 1);
        check("t5_total_after", load_total, 1);
        load_allow = 1'b0;

        // T6: 65537 pops after reset wrap load_total to 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_allow = 1'b1; in_valid = 1'b1;
        pops = 0;
        for (k = 0; k < 70000 && pops < 65537; k++) begin
            in_data = W'($urandom_range(0, 255));
            #2;
            if (reg_enable) pops++;
            tick();
        end
        load_allow = 1'b0; in_valid = 1'b0;
        log_q.delete();
        check("t6_pops_done", pops, 65537);
        #2;
        check("t6_load_total", load_total, 1);
        tick();
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
